arb_mux_nway: RTL



---
 rtl/arb_mux_nway_if.sv | 25 ++
 rtl/arb_mux_nway.sv | 98 +++++++++
 2 files changed

// File: rtl/arb_mux_nway_if.sv
// Handshake bundle between N producers and one consumer for arb_mux_nway.
// The slave modport is the mux side; the master modport is the producer/consumer side.
interface arb_mux_nway_if #(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int SELW  = $clog2(N)
) ();
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N*WIDTH-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/arb_mux_nway.sv
// N-way arbitrated mux: round-robin or fixed-priority grant feeding a single
// registered output slot with valid/ready on every side.
module arb_mux_nway #(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int SELW  = $clog2(N),
    parameter int MODE  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    arb_mux_nway_if.slave bus
);
    logic [WIDTH-1:0] ch_data [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
    end

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_sel_q,   out_sel_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;

    logic             can_accept;
    logic             found;
    logic             take;
    logic [SELW-1:0]  grant_idx;
    logic [SELW:0]    cand;
    logic [N-1:0]     in_ready;

    assign can_accept = !out_valid_q || bus.out_ready;

    // Candidate index is ptr+k folded back below N; the extra bit covers ptr+k up to 2N-2.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            if (MODE == 0) begin
                cand = {1'b0, ptr_q} + (SELW+1)'(k);
            end else begin
                cand = (SELW+1)'(k);
            end
            if (cand >= (SELW+1)'(N)) begin
                cand = cand - (SELW+1)'(N);
            end
            if (!found && bus.in_valid[cand[SELW-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[SELW-1:0];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && can_accept && found) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign take = |in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (take) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_data[grant_idx];
            out_sel_d   = grant_idx;
            if (MODE == 0) begin
                ptr_d = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule
